// File: rtl/match_tally.sv
// ============================================================================
// match_tally : turns each high run of ans_in into one event, keeps a
//               saturating total and a per-window count with threshold alarm.
// Rev 1.0
// ============================================================================
`default_nettype none

module match_tally #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ans_in,
  input  logic             clr,
  output logic [CNT_W-1:0] total,
  output logic [CNT_W-1:0] win_count,
  output logic             win_valid,
  output logic             alarm,
  output logic             overflow
);

  localparam int               PH_W      = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [PH_W-1:0]  c_PH_LAST = PH_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] c_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_MAX_M1  = c_MAX - 1'b1;
  localparam logic [CNT_W-1:0] c_THRESH  = CNT_W'(THRESH);

  logic             r_prev;
  logic [PH_W-1:0]  r_ph;
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_win_count;
  logic             r_win_valid;
  logic             r_alarm;
  logic             r_overflow;

  logic             w_event;
  logic             w_close;
  logic [CNT_W-1:0] w_run_next;

  assign w_event    = ans_in & ~r_prev;
  assign w_close    = (r_ph == c_PH_LAST);
  // An event on the closing edge is folded into the closing window's count.
  assign w_run_next = (w_event && (r_run != c_MAX)) ? r_run + 1'b1 : r_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= 1'b0;
      r_ph        <= '0;
      r_run       <= '0;
      r_total     <= '0;
      r_win_count <= '0;
      r_win_valid <= 1'b0;
      r_alarm     <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clr) begin
      // Capture the current level so an already-high ans_in is not recounted.
      r_prev      <= ans_in;
      r_ph        <= '0;
      r_run       <= '0;
      r_total     <= '0;
      r_win_count <= '0;
      r_win_valid <= 1'b0;
      r_alarm     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_prev <= ans_in;

      if (w_event && (r_total != c_MAX)) begin
        r_total <= r_total + 1'b1;
        if (r_total == c_MAX_M1) begin
          r_overflow <= 1'b1;
        end
      end

      if (w_close) begin
        r_ph        <= '0;
        r_run       <= '0;
        r_win_count <= w_run_next;
        r_win_valid <= 1'b1;
        r_alarm     <= (w_run_next >= c_THRESH);
      end else begin
        r_ph        <= r_ph + 1'b1;
        r_run       <= w_run_next;
        r_win_valid <= 1'b0;
      end
    end
  end

  assign total     = r_total;
  assign win_count = r_win_count;
  assign win_valid = r_win_valid;
  assign alarm     = r_alarm;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire
